// File: rtl/cci_mpf_c0_rd_arbiter.sv
// Round-robin sharing of the MPF c0 read-request channel among N_REQ requesters, with
// per-requester credit limits, tag-based response steering and a drain handshake.
// Define CCI_MPF_RD_ARB_STATS_EN to build the per-requester grant counters.
module cci_mpf_c0_rd_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int REQ_W   = 128,
    parameter  int MAX_OUT = 64,
    localparam int TAG_W   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*REQ_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   c0_alm_full,
    output logic                   tx_valid,
    output logic [REQ_W-1:0]       tx_data,
    output logic [TAG_W-1:0]       tx_tag,
    input  logic                   rsp_valid,
    input  logic [TAG_W-1:0]       rsp_tag,
    output logic [N_REQ-1:0]       rsp_route,
    input  logic                   drain_req,
    output logic                   drain_done,
    output logic                   tag_err,
    output logic [N_REQ*32-1:0]    stat_grants
);

    localparam int               CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAINING = 2'd1,
        DRAINED  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TAG_W-1:0] ptr;
    logic [CNT_W-1:0] out_cnt [N_REQ];
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] rsp_dec;
    logic             cnt_zero;
    logic             grant_vld;
    logic [TAG_W-1:0] grant_idx;
    logic [REQ_W-1:0] grant_data;
    logic             tag_err_set;

    always_comb begin
        rsp_route = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_route[i] = rsp_valid && (rsp_tag == TAG_W'(i));
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        eligible = '0;
        rsp_dec  = '0;
        cnt_zero = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (out_cnt[i] < CNT_MAX);
            rsp_dec[i]  = rsp_route[i] && (out_cnt[i] != '0);
            if (out_cnt[i] != '0) begin
                cnt_zero = 1'b0;
            end
        end
    end

    // A response that decrements nothing is either out of range or unmatched.
    assign tag_err_set = rsp_valid && (rsp_dec == '0);

    // First eligible requester at or after the pointer, wrapping at N_REQ.
    always_comb begin : arb
        int idx;
        idx        = 0;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        req_ready  = '0;
        if ((state == RUN) && !c0_alm_full) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                if (!grant_vld && eligible[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = TAG_W'(idx);
                end
            end
        end
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                grant_data = req_data[i*REQ_W +: REQ_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (drain_req) begin
                    state_nxt = DRAINING;
                end
            end
            DRAINING: begin
                if (!drain_req) begin
                    state_nxt = RUN;
                end else if (cnt_zero && !tx_valid) begin
                    state_nxt = DRAINED;
                end
            end
            DRAINED: begin
                if (!drain_req) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign drain_done = (state == DRAINED);

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_tag   <= '0;
            ptr      <= '0;
            tag_err  <= 1'b0;
        end else begin
            tx_valid <= grant_vld;
            if (grant_vld) begin
                tx_data <= grant_data;
                tx_tag  <= grant_idx;
                ptr     <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (tag_err_set) begin
                tag_err <= 1'b1;
            end
        end
    end

    // NOTE: the counter array is reset explicitly: credit accounting must restart from
    // zero, so this storage cannot be left to power-up contents like a data RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                out_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i] && !rsp_dec[i]) begin
                    out_cnt[i] <= out_cnt[i] + 1'b1;
                end else if (!req_ready[i] && rsp_dec[i]) begin
                    out_cnt[i] <= out_cnt[i] - 1'b1;
                end
            end
        end
    end

`ifdef CCI_MPF_RD_ARB_STATS_EN
    logic [31:0] stat_q [N_REQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < N_REQ; i++) begin
            stat_grants[i*32 +: 32] = stat_q[i];
        end
    end
`else
    assign stat_grants = '0;
`endif

endmodule
